generador_producto_lockin: RTL and testbench
============================================

Name: generador_producto_lockin

Overview:
Source end of the 64-bit lock-in Avalon-ST sample stream. It multiplies each ADC sample by a reference value taken from a programmable one-period table, indexed modulo ptos_x_ciclo. The signed product is emitted as data/data_valid to the moving-average filter downstream. The block starts only after the filter reports ready_to_calculate, and stops feeding when the filter reports calculo_finalizado.

Parameters:
TAB_TAM, 4096, reference table depth in entries; ptos_x_ciclo must not exceed it.
ADC_W, 14, signed ADC sample width.
REF_W, 16, signed reference sample width.

Ports:
clock  in  1  single system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  run request from the control registers
ptos_x_ciclo  in  16  M, points per reference period
ref_wr_en  in  1  reference table write strobe
ref_wr_addr  in  12  table write address (log2 TAB_TAM)
ref_wr_data  in  REF_W  signed table write data
adc_valid  in  1  ADC sample strobe
adc_data  in  ADC_W  signed ADC sample
ready_to_calculate  in  1  filter has finished clearing its buffers
calculo_finalizado  in  1  filter is done; stop feeding
data_out  out  64  signed product, sign-extended to 64 bits
data_out_valid  out  1  data_out qualifier, one cycle per product
muestras_enviadas  out  32  count of products emitted since run start
estado  out  2  current FSM state
error_config  out  1  M==0 or M>TAB_TAM at run request

Behaviour:
- Reset values, applied asynchronously: data_out=0, data_out_valid=0, muestras_enviadas=0, estado=IDLE, error_config=0, table index=0, all pipeline valids=0. Table RAM contents are not cleared.
- FSM state IDLE(0): when enable=1, latch M.
  - If M==0 or M>TAB_TAM, set error_config=1 and stay in IDLE.
  - Otherwise clear error_config, index and muestras_enviadas, then go to WAIT(1).
- FSM state WAIT(1): when ready_to_calculate=1, go to RUN(2).
- FSM state RUN(2): each adc_valid accepts one sample. When calculo_finalizado=1, go to DONE(3).
- FSM state DONE(3): no new samples are accepted. When enable=0, go to IDLE.
- enable=0 in WAIT or RUN: go to IDLE on the next clock. Pipeline valids are cleared, so no further outputs appear.
- Sample acceptance: a sample is accepted only when estado==RUN, adc_valid=1 and calculo_finalizado=0. If adc_valid and calculo_finalizado rise in the same cycle, the sample is not accepted.
- Pipeline, 3 cycles from accepted adc_valid to data_out_valid:
  - s1: register adc_data and read ref[idx].
  - s2: signed multiply, ADC_W+REF_W bits.
  - s3: sign-extend to 64 bits, drive data_out, pulse data_out_valid.
- Index on acceptance: idx <= (idx==M-1) ? 0 : idx+1.
- Samples already in flight at the stop still emerge, 1 to 3 of them. muestras_enviadas increments on each data_out_valid.
- The product is exact; there is no saturation or rounding. Worst case is -2^(ADC_W-1) * -2^(REF_W-1), positive and within range.
- data_out holds its last value while data_out_valid=0.
- Table writes:
  - Honoured only in IDLE or DONE. ref_wr_en in WAIT or RUN is ignored.
  - The RAM has one write port and one read port. A write and a read never conflict, because reads happen only in RUN.
- Consecutive adc_valid cycles are fully pipelined, giving one product per clock. There is no backpressure input; the filter always accepts.

Decomposition:
- Package lockin_pkg holds:
  - estado encodings IDLE/WAIT/RUN/DONE;
  - widths ADC_W, REF_W and the 64-bit stream width;
  - the TAB_TAM default.
- One sub-module, tabla_referencia: a simple dual-port RAM with registered read, inferred as block RAM, TAB_TAM x REF_W.

Test Plan:
- Gain check: M=4, table {1,2,3,4}, ready=1, adc=100 for 8 consecutive samples -> data_out 100,200,300,400,100,200,300,400, first valid 3 cycles after the first adc_valid, muestras_enviadas=8.
- Sign extremes: table[0]=-32768, M=1, adc=-8192 -> data_out=268435456. adc=8191 -> -268402688, upper bits sign-extended (0xFFFFFFFF...).
- Handshake: hold ready_to_calculate=0 for 50 cycles while adc_valid toggles -> no outputs, estado=1. Raise ready -> RUN begins and the first product uses table[0].
- Stop: assert calculo_finalizado after the 5th accepted sample, with adc_valid continuous -> exactly 5 outputs, estado=3. Clear enable -> estado=0.
- Config error and write lockout:
  - M=0 with enable=1 -> error_config=1, no outputs.
  - M=4099 -> same result.
  - ref_wr_en during RUN -> the table value is unchanged on the next period.
- Reset mid-run: drop reset_n with 2 products in flight -> outputs and counters clear immediately, no stray data_out_valid, table contents retained after reset.

Source files
------------

// File: rtl/generador_producto_lockin_pkg.sv
// Shared encodings and widths for the lock-in product generator.
package lockin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } estado_t;

    localparam int ADC_W       = 14;
    localparam int REF_W       = 16;
    localparam int PROD_W      = ADC_W + REF_W;
    localparam int STREAM_W    = 64;
    localparam int TAB_TAM_DEF = 4096;
    localparam int ADDR_W      = $clog2(TAB_TAM_DEF);
    localparam int M_W         = 16;
    localparam int CNT_W       = 32;

endpackage

// File: rtl/generador_producto_lockin_if.sv
// Control, table-write, ADC and filter-stream signals of the product generator.
interface generador_producto_lockin_if;
    import lockin_pkg::*;

    logic                       enable;
    logic [M_W-1:0]             ptos_x_ciclo;
    logic                       ref_wr_en;
    logic [ADDR_W-1:0]          ref_wr_addr;
    logic signed [REF_W-1:0]    ref_wr_data;
    logic                       adc_valid;
    logic signed [ADC_W-1:0]    adc_data;
    logic                       ready_to_calculate;
    logic                       calculo_finalizado;
    logic signed [STREAM_W-1:0] data_out;
    logic                       data_out_valid;
    logic [CNT_W-1:0]           muestras_enviadas;
    logic [1:0]                 estado;
    logic                       error_config;

    // master: the generator itself (source of the product stream)
    modport master (
        input  enable, ptos_x_ciclo, ref_wr_en, ref_wr_addr, ref_wr_data,
               adc_valid, adc_data, ready_to_calculate, calculo_finalizado,
        output data_out, data_out_valid, muestras_enviadas, estado, error_config
    );

    modport slave (
        output enable, ptos_x_ciclo, ref_wr_en, ref_wr_addr, ref_wr_data,
               adc_valid, adc_data, ready_to_calculate, calculo_finalizado,
        input  data_out, data_out_valid, muestras_enviadas, estado, error_config
    );

endinterface

// File: rtl/generador_producto_lockin_tabla_referencia.sv
// One-period reference table: simple dual-port RAM with registered read (block RAM).
module tabla_referencia
    import lockin_pkg::*;
#(
    parameter int DEPTH = TAB_TAM_DEF,
    parameter int WIDTH = REF_W,
    parameter int AW    = ADDR_W
) (
    input  logic             i_clock,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clock) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/generador_producto_lockin.sv
// Multiplies each accepted ADC sample by ref[idx mod M] and streams the
// sign-extended product to the moving-average filter (3-cycle pipeline).
module generador_producto_lockin
    import lockin_pkg::*;
#(
    parameter int TAB_TAM = TAB_TAM_DEF
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    generador_producto_lockin_if.master  io_lockin
);

    localparam int STAGES = 3;

    estado_t                    r_estado, w_estado_nx;
    logic [M_W-1:0]             r_m;
    logic [ADDR_W-1:0]          r_idx;
    logic                       r_error_config;
    logic [CNT_W-1:0]           r_cnt;
    logic [STAGES:1]            r_vld_pipe;
    logic signed [ADC_W-1:0]    r_adc_s1;
    logic signed [REF_W-1:0]    w_ref_s1;
    logic signed [PROD_W-1:0]   r_prod_s2;
    logic signed [STREAM_W-1:0] r_data_out;

    logic w_accept, w_flush, w_start, w_cfg_err, w_cfg_bad, w_wr_en, w_idx_wrap;

    assign w_cfg_bad  = (io_lockin.ptos_x_ciclo == '0) ||
                        ({16'd0, io_lockin.ptos_x_ciclo} > 32'(TAB_TAM));
    assign w_accept   = (r_estado == ST_RUN) && io_lockin.adc_valid &&
                        !io_lockin.calculo_finalizado;
    assign w_idx_wrap = ({{(M_W-ADDR_W){1'b0}}, r_idx} == (r_m - 16'd1));
    // Reads happen only in RUN, so confining writes to IDLE/DONE avoids port conflicts
    assign w_wr_en    = io_lockin.ref_wr_en &&
                        ((r_estado == ST_IDLE) || (r_estado == ST_DONE));

    always_comb begin
        w_estado_nx = r_estado;
        w_start     = 1'b0;
        w_cfg_err   = 1'b0;
        w_flush     = 1'b0;
        case (r_estado)
            ST_IDLE: begin
                if (io_lockin.enable) begin
                    if (w_cfg_bad) begin
                        w_cfg_err = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_estado_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!io_lockin.enable) begin
                    w_flush     = 1'b1;
                    w_estado_nx = ST_IDLE;
                end else if (io_lockin.ready_to_calculate) begin
                    w_estado_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!io_lockin.enable) begin
                    w_flush     = 1'b1;
                    w_estado_nx = ST_IDLE;
                end else if (io_lockin.calculo_finalizado) begin
                    w_estado_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!io_lockin.enable) w_estado_nx = ST_IDLE;
            end
            default: w_estado_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_estado       <= ST_IDLE;
            r_error_config <= 1'b0;
            r_m            <= '0;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_vld_pipe     <= '0;
            r_data_out     <= '0;
        end else begin
            r_estado <= w_estado_nx;

            if (w_cfg_err)    r_error_config <= 1'b1;
            else if (w_start) r_error_config <= 1'b0;

            if (w_start) begin
                r_m   <= io_lockin.ptos_x_ciclo;
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= w_idx_wrap ? '0 : r_idx + 1'b1;
            end

            r_vld_pipe <= w_flush ? '0 : {r_vld_pipe[STAGES-1:1], w_accept};

            // Counter and data_out advance in the same edge that raises data_out_valid
            if (w_start)
                r_cnt <= '0;
            else if (r_vld_pipe[STAGES-1] && !w_flush)
                r_cnt <= r_cnt + 1'b1;

            if (r_vld_pipe[STAGES-1] && !w_flush)
                r_data_out <= {{(STREAM_W-PROD_W){r_prod_s2[PROD_W-1]}}, r_prod_s2};
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_accept)      r_adc_s1  <= io_lockin.adc_data;
        if (r_vld_pipe[1]) r_prod_s2 <= PROD_W'(r_adc_s1) * PROD_W'(w_ref_s1);
    end

    tabla_referencia #(
        .DEPTH (TAB_TAM),
        .WIDTH (REF_W),
        .AW    (ADDR_W)
    ) u_tabla (
        .i_clock   (i_clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (io_lockin.ref_wr_addr),
        .i_wr_data (io_lockin.ref_wr_data),
        .i_rd_en   (w_accept),
        .i_rd_addr (r_idx),
        .o_rd_data (w_ref_s1)
    );

    assign io_lockin.data_out          = r_data_out;
    assign io_lockin.data_out_valid    = r_vld_pipe[STAGES];
    assign io_lockin.muestras_enviadas = r_cnt;
    assign io_lockin.estado            = r_estado;
    assign io_lockin.error_config      = r_error_config;

endmodule

// File: tb/tb_generador_producto_lockin.sv
// Bench for the lock-in product generator: scripted sequences, a vector table
// and randomized runs checked against a queue-based product model.
module tb_generador_producto_lockin;
    import lockin_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    generador_producto_lockin_if bus();

    generador_producto_lockin #(.TAB_TAM(4096)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .io_lockin (bus)
    );

    typedef struct {
        int     ref_v;
        int     adc;
        longint exp;
    } vec_t;

    int     tests = 0;
    int     fails = 0;
    int     cyc   = 0;
    longint exp_q[$];
    int     out_cyc_q[$];
    int     mtab[4096];
    int     m_m, m_idx, m_cnt;
    bit     m_run = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Every product leaving the block must match the oldest expected product
    always @(negedge clk) begin
        if (rst_n && bus.data_out_valid) begin
            out_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid got=%0d exp=none", bus.data_out);
            end else begin
                chk("data_out", bus.data_out, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int a, input int v, input bit upd);
        bus.ref_wr_en   = 1'b1;
        bus.ref_wr_addr = 12'(a);
        bus.ref_wr_data = 16'(v);
        tick();
        bus.ref_wr_en = 1'b0;
        if (upd) mtab[a] = v;
    endtask

    task automatic start(input int m);
        bus.ptos_x_ciclo = 16'(m);
        bus.enable       = 1'b1;
        tick();
        m_m   = m;
        m_idx = 0;
        m_cnt = 0;
    endtask

    task automatic run(input int m);
        start(m);
        bus.ready_to_calculate = 1'b1;
        tick();
        m_run = 1'b1;
    endtask

    task automatic sample(input int adc, input bit v = 1'b1);
        bus.adc_valid = v;
        bus.adc_data  = 14'(adc);
        if (v && m_run && !bus.calculo_finalizado) begin
            exp_q.push_back(longint'(adc) * longint'(mtab[m_idx]));
            m_idx = (m_idx + 1) % m_m;
            m_cnt++;
        end
        tick();
        bus.adc_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic stop();
        bus.enable             = 1'b0;
        bus.ready_to_calculate = 1'b0;
        m_run                  = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   c0;
        vt[0] = '{-32768, -8192, 64'sd268435456};
        vt[1] = '{-32768,  8191, -64'sd268402688};
        vt[2] = '{ 32767,  8191, 64'sd268394497};
        vt[3] = '{ 32767, -8192, -64'sd268427264};
        vt[4] = '{     0,  1234, 64'sd0};
        vt[5] = '{    -1,    -1, 64'sd1};

        bus.enable = 0; bus.ptos_x_ciclo = 0; bus.ref_wr_en = 0; bus.ref_wr_addr = 0;
        bus.ref_wr_data = 0; bus.adc_valid = 0; bus.adc_data = 0;
        bus.ready_to_calculate = 0; bus.calculo_finalizado = 0;

        // Reset state
        tick(3);
        chk("rst_estado", bus.estado, 0);
        chk("rst_valid", bus.data_out_valid, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_cnt", bus.muestras_enviadas, 0);
        chk("rst_err", bus.error_config, 0);
        rst_n = 1'b1;
        tick();

        // Gain: M=4, table {1,2,3,4}, 8 back-to-back samples of 100
        for (int i = 0; i < 4; i++) wr(i, i + 1, 1'b1);
        run(4);
        out_cyc_q.delete();
        c0 = cyc;
        for (int i = 0; i < 8; i++) sample(100);
        drain();
        chk("gain_outs", out_cyc_q.size(), 8);
        if (out_cyc_q.size() >= 8) begin
            chk("gain_latency", out_cyc_q[0] - c0, 3);
            chk("gain_burst", out_cyc_q[7] - out_cyc_q[0], 7);
        end
        chk("gain_cnt", bus.muestras_enviadas, 8);
        chk("gain_last", bus.data_out, 400);
        stop();

        // Sign extremes, M=1
        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v = vt[i];
            wr(0, v.ref_v, 1'b1);
            run(1);
            sample(v.adc);
            drain();
            chk("vec_data", bus.data_out, v.exp);
            chk("vec_hi", longint'(bus.data_out[63:32]), longint'(v.exp[63:32]));
            tick(3);
            chk("vec_hold", bus.data_out, v.exp);
            stop();
        end

        // Handshake: held in WAIT while ready is low
        for (int i = 0; i < 4; i++) wr(i, 10 * (i + 1), 1'b1);
        out_cyc_q.delete();
        start(4);
        for (int i = 0; i < 50; i++) sample(5, 1'(i % 2));
        chk("hs_wait_estado", bus.estado, 1);
        chk("hs_wait_outs", out_cyc_q.size(), 0);
        bus.ready_to_calculate = 1'b1;
        tick();
        m_run = 1'b1;
        chk("hs_run_estado", bus.estado, 2);
        sample(7);
        drain();
        chk("hs_first", bus.data_out, 70);
        stop();

        // Stop: finalizado after 5th accepted sample, adc_valid continuous
        run(4);
        out_cyc_q.delete();
        for (int i = 0; i < 5; i++) sample(i + 1);
        bus.calculo_finalizado = 1'b1;
        for (int i = 0; i < 4; i++) sample(99);
        m_run = 1'b0;
        drain();
        tick(3);
        chk("stop_outs", out_cyc_q.size(), 5);
        chk("stop_estado", bus.estado, 3);
        chk("stop_cnt", bus.muestras_enviadas, 5);
        bus.calculo_finalizado = 1'b0;
        sample(55);
        tick(4);
        chk("done_hold", bus.estado, 3);
        chk("done_no_accept", out_cyc_q.size(), 5);
        bus.enable = 1'b0;
        tick();
        chk("done_idle", bus.estado, 0);

        // Configuration errors and the TAB_TAM boundary
        out_cyc_q.delete();
        bus.ptos_x_ciclo = 0; bus.enable = 1'b1; bus.ready_to_calculate = 1'b1;
        for (int i = 0; i < 4; i++) sample(3);
        chk("m0_err", bus.error_config, 1);
        chk("m0_estado", bus.estado, 0);
        bus.enable = 1'b0; tick();
        bus.ptos_x_ciclo = 4099; bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) sample(3);
        chk("m4099_err", bus.error_config, 1);
        chk("m4099_estado", bus.estado, 0);
        chk("cfg_no_outs", out_cyc_q.size(), 0);
        bus.enable = 1'b0; bus.ready_to_calculate = 1'b0; tick();
        start(4096);
        chk("m4096_err", bus.error_config, 0);
        chk("m4096_estado", bus.estado, 1);
        stop();

        // Table write during RUN is ignored
        run(4);
        sample(2); sample(2);
        wr(0, 999, 1'b0);
        sample(2); sample(2); sample(2);
        drain();
        chk("lockout", bus.data_out, 20);
        stop();

        // Randomized runs with ignored writes sprinkled in
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 16; a++) wr(a, int'($urandom_range(0, 65535)) - 32768, 1'b1);
            run(int'($urandom_range(1, 16)));
            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 9) == 0)
                    wr(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)) - 32768, 1'b0);
                else
                    sample(int'($urandom_range(0, 16383)) - 8192, 1'($urandom_range(0, 1)));
            end
            drain();
            chk("rand_cnt", bus.muestras_enviadas, m_cnt);
            stop();
        end

        // Reset with products in flight
        for (int i = 0; i < 4; i++) wr(i, 2 * i + 3, 1'b1);
        run(4);
        for (int i = 0; i < 4; i++) sample(11);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstrun_valid", bus.data_out_valid, 0);
        chk("rstrun_data", bus.data_out, 0);
        chk("rstrun_cnt", bus.muestras_enviadas, 0);
        chk("rstrun_estado", bus.estado, 0);
        exp_q.delete();
        m_run = 1'b0;
        bus.enable = 1'b0;
        bus.ready_to_calculate = 1'b0;
        out_cyc_q.delete();
        tick(3);
        chk("rstrun_quiet", out_cyc_q.size(), 0);
        rst_n = 1'b1;
        tick();
        run(4);
        for (int i = 0; i < 4; i++) sample(1);
        drain();
        chk("rstrun_table", bus.data_out, 9);
        stop();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
